vga_timing_gen: RTL and testbench

Produces 640x480@60 Hz VGA raster timing from the 25 MHz pixel clock and drives the pixel coordinates consumed by `img_generator`. It samples the 3-bit `color` that `img_generator` returns for those coordinates and registers it, blanked outside the visible area, onto the VGA pins, with sync aligned. It sits between `img_generator` and the board VGA connector; it is the consumer end of the x/y → color interface.

---
 rtl/vga_timing_gen.sv | 111 +++++++++++
 tb/tb_vga_timing_gen.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: x/y counters out, registered blanked RGB + syncs back.
// Latency: RGB/HS/VS/video_on lag x/y by exactly one clock. frame_start is aligned with x=0,y=0.
// Backpressure: none. Free-running every clock. Optional define VGA_TEST_PATTERN_EN replaces color with bars.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        CLOCK_25,
  input  logic        RESET_N,
  input  logic [2:0]  color,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_R,
  output logic        VGA_G,
  output logic        VGA_B,
  output logic        video_on,
  output logic        frame_start
);

  localparam logic [11:0] H_LAST   = 12'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [11:0] V_LAST   = 12'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [11:0] H_VIS    = 12'(H_VISIBLE);
  localparam logic [11:0] V_VIS    = 12'(V_VISIBLE);
  localparam logic [11:0] HS_START = 12'(H_VISIBLE + H_FRONT);
  localparam logic [11:0] HS_END   = 12'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [11:0] VS_START = 12'(V_VISIBLE + V_FRONT);
  localparam logic [11:0] VS_END   = 12'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [11:0] h_cnt_q, h_cnt_d;
  logic [11:0] v_cnt_q, v_cnt_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic [2:0]  rgb_q, rgb_d;
  logic        video_on_q, video_on_d;
  logic        frame_start_q, frame_start_d;

  logic        h_last;
  logic        v_last;
  logic        visible;

`ifdef VGA_TEST_PATTERN_EN
  // Input color is deliberately ignored while the bar pattern is selected.
  logic color_unused;
  assign color_unused = ^color;
`endif

  // Counter advance and output-stage decode from the current counter position.
  always_comb begin
    h_last  = (h_cnt_q == H_LAST);
    v_last  = (v_cnt_q == V_LAST);

    h_cnt_d = h_last ? 12'd0 : h_cnt_q + 12'd1;
    v_cnt_d = v_cnt_q;
    if (h_last) begin
      v_cnt_d = v_last ? 12'd0 : v_cnt_q + 12'd1;
    end

    visible    = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    hs_d       = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
    vs_d       = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
    video_on_d = visible;
`ifdef VGA_TEST_PATTERN_EN
    // Vertical bars, 128 pixels wide, valued 0..4 across the visible line.
    rgb_d      = visible ? h_cnt_q[9:7] : 3'b000;
`else
    rgb_d      = visible ? color : 3'b000;
`endif
    // Next position is (0,0), so the pulse lands with x=0,y=0 on the outputs.
    frame_start_d = h_last && v_last;
  end

  // Counters and registered output stage; reset parks syncs inactive.
  always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
    if (!RESET_N) begin
      h_cnt_q       <= 12'd0;
      v_cnt_q       <= 12'd0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      rgb_q         <= 3'b000;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      rgb_q         <= rgb_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign x           = h_cnt_q;
  assign y           = v_cnt_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_R       = rgb_q[2];
  assign VGA_G       = rgb_q[1];
  assign VGA_B       = rgb_q[0];
  assign video_on    = video_on_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: one full-size instance (line timing) and one shrunken instance
// (frame/vsync timing within a short run), both checked every cycle against an arithmetic model.
// Random color each cycle; mid-frame reset while in hsync and vsync.
module tb_vga_timing_gen;

  // Shrunken timing for the second instance: line 58 clocks, frame 39 lines.
  localparam int SHV = 40, SHF = 4, SHS = 8, SHB = 6;
  localparam int SVV = 30, SVF = 3, SVS = 2, SVB = 4;
  localparam int S_FRAME = (SHV + SHF + SHS + SHB) * (SVV + SVF + SVS + SVB);

  logic        clk;
  logic        rst_n;
  logic [2:0]  color;

  logic [11:0] d_x, d_y, s_x, s_y;
  logic        d_hs, d_vs, d_r, d_g, d_b, d_vo, d_fs;
  logic        s_hs, s_vs, s_r, s_g, s_b, s_vo, s_fs;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  longint      k     = 0;
  int          fs_cnt = 0;

  vga_timing_gen u_dut (
    .CLOCK_25(clk), .RESET_N(rst_n), .color(color),
    .x(d_x), .y(d_y), .VGA_HS(d_hs), .VGA_VS(d_vs),
    .VGA_R(d_r), .VGA_G(d_g), .VGA_B(d_b),
    .video_on(d_vo), .frame_start(d_fs)
  );

  vga_timing_gen #(
    .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
  ) u_dut_s (
    .CLOCK_25(clk), .RESET_N(rst_n), .color(color),
    .x(s_x), .y(s_y), .VGA_HS(s_hs), .VGA_VS(s_vs),
    .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b),
    .video_on(s_vo), .frame_start(s_fs)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s k=%0d got=%0d exp=%0d", tag, k, got, exp);
    end
  endtask

  // Reference: after k rising edges since release the counters sit at position k,
  // while the output stage shows pixel k-1 (reset values when k==0).
  task automatic check_all(input string nm,
                           input int hv, input int hf, input int hsw, input int hb,
                           input int vv, input int vf, input int vsw, input int vb,
                           input logic [2:0] cp,
                           input logic [11:0] gx, input logic [11:0] gy,
                           input logic ghs, input logic gvs, input logic [2:0] grgb,
                           input logic gvo, input logic gfs);
    longint ht, vt, px, py, p;
    logic   e_hs, e_vs, e_vo, e_fs;
    logic [2:0] e_rgb;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    e_hs = 1'b1; e_vs = 1'b1; e_vo = 1'b0; e_rgb = 3'b000; e_fs = 1'b0;
    if (k > 0) begin
      p    = k - 1;
      px   = p % ht;
      py   = (p / ht) % vt;
      e_vo = (px < hv) && (py < vv);
      e_hs = !((px >= hv + hf) && (px < hv + hf + hsw));
      e_vs = !((py >= vv + vf) && (py < vv + vf + vsw));
`ifdef VGA_TEST_PATTERN_EN
      e_rgb = e_vo ? 3'((px / 128) % 8) : 3'b000;
`else
      e_rgb = e_vo ? cp : 3'b000;
`endif
      e_fs = (k % (ht * vt)) == 0;
    end
    chk({nm, ".x"},   32'(gx),   32'(k % ht));
    chk({nm, ".y"},   32'(gy),   32'((k / ht) % vt));
    chk({nm, ".hs"},  32'(ghs),  32'(e_hs));
    chk({nm, ".vs"},  32'(gvs),  32'(e_vs));
    chk({nm, ".rgb"}, 32'(grgb), 32'(e_rgb));
    chk({nm, ".vo"},  32'(gvo),  32'(e_vo));
    chk({nm, ".fs"},  32'(gfs),  32'(e_fs));
  endtask

  task automatic check_both();
    check_all("def", 640, 16, 96, 48, 480, 10, 2, 33, color,
              d_x, d_y, d_hs, d_vs, {d_r, d_g, d_b}, d_vo, d_fs);
    check_all("sml", SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, color,
              s_x, s_y, s_hs, s_vs, {s_r, s_g, s_b}, s_vo, s_fs);
  endtask

  // Advance one clock, check at the falling edge, then pick a fresh color.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    k++;
    if (s_fs === 1'b1) fs_cnt++;
    check_both();
    color = 3'($urandom_range(7, 0));
  endtask

  initial begin
    longint stop_k;
    rst_n = 1'b0;
    color = 3'($urandom_range(7, 0));
    k     = 0;

    // Held in reset: outputs stay at reset values across edges.
    repeat (3) begin
      @(negedge clk);
      check_both();
      color = 3'($urandom_range(7, 0));
    end

    // Release away from the edge; the next rising edge is the first count.
    rst_n = 1'b1;
    k     = 0;

    // Two full shrunken frames, then into the third frame up to output pixel (48,34):
    // both syncs are active on the small instance there.
    stop_k = 2 * S_FRAME + 34 * (SHV + SHF + SHS + SHB) + 49;
    while (k < stop_k) step();

    chk("sml.fs_count", 32'(fs_cnt), 32'd2);
    chk("sml.hs_pre_rst", 32'(s_hs), 32'd0);
    chk("sml.vs_pre_rst", 32'(s_vs), 32'd0);

    // Mid-frame reset: everything returns at once, without waiting for an edge.
    rst_n = 1'b0;
    #1;
    k = 0;
    check_both();

    @(negedge clk);
    check_both();
    rst_n = 1'b1;
    k     = 0;
    repeat (10) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
